// File: rtl/icache_responder.sv
// Direct-mapped instruction cache answering fetcher pc requests and
// refilling whole lines from the memory controller one word per beat.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_EN.
module icache_responder #(
    parameter int unsigned INDEX_BITS  = 6,
    parameter int unsigned OFFSET_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    input  logic        IF_pc_sgn,
    input  logic [31:0] IF_pc,
    output logic        IF_ins_sgn,
    output logic [31:0] IF_ins,
    output logic        MC_req,
    output logic [31:0] MC_addr,
    input  logic        MC_done,
    input  logic [31:0] MC_data
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int unsigned LINES     = 2 ** INDEX_BITS;
    localparam int unsigned ADDR_BITS = INDEX_BITS + OFFSET_BITS;
    localparam int unsigned WORDS     = 2 ** ADDR_BITS;
    localparam int unsigned TAG_LSB   = 2 + OFFSET_BITS + INDEX_BITS;
    localparam int unsigned TAG_BITS  = 32 - TAG_LSB;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REFILL,
        S_GAP,
        S_RESP,
        S_DRAIN
    } state_t;

    // State and datapath registers
    state_t                 r_state;
    logic [31:0]            r_req_pc;
    logic [OFFSET_BITS-1:0] r_beat;
    logic [31:0]            r_hold;

    // Cache storage; only the valid bits are reset
    logic [LINES-1:0]       r_valid;
    logic [TAG_BITS-1:0]    r_tag  [LINES];
    logic [31:0]            r_data [WORDS];

    // Next-state and control signals
    state_t                 w_state_nxt;
    logic [31:0]            w_req_pc_nxt;
    logic [OFFSET_BITS-1:0] w_beat_nxt;
    logic [31:0]            w_hold_nxt;
    logic                   w_ins_sgn_nxt;
    logic [31:0]            w_ins_nxt;
    logic                   w_mc_req_nxt;
    logic [31:0]            w_mc_addr_nxt;
    logic                   w_data_we;
    logic                   w_line_fill;
    logic                   w_line_inval;
    logic                   w_hit_inc;
    logic                   w_miss_inc;

    // Address field decode for the incoming and the latched request
    logic [OFFSET_BITS-1:0] w_in_off;
    logic [INDEX_BITS-1:0]  w_in_idx;
    logic [TAG_BITS-1:0]    w_in_tag;
    logic [OFFSET_BITS-1:0] w_req_off;
    logic [INDEX_BITS-1:0]  w_req_idx;
    logic [TAG_BITS-1:0]    w_req_tag;
    logic                   w_hit;
    logic [31:0]            w_hit_word;
    logic [ADDR_BITS-1:0]   w_fill_addr;
    logic                   w_unused;

    assign w_in_off    = IF_pc[2 +: OFFSET_BITS];
    assign w_in_idx    = IF_pc[2 + OFFSET_BITS +: INDEX_BITS];
    assign w_in_tag    = IF_pc[31:TAG_LSB];
    assign w_req_off   = r_req_pc[2 +: OFFSET_BITS];
    assign w_req_idx   = r_req_pc[2 + OFFSET_BITS +: INDEX_BITS];
    assign w_req_tag   = r_req_pc[31:TAG_LSB];
    assign w_hit       = r_valid[w_in_idx] && (r_tag[w_in_idx] == w_in_tag);
    assign w_hit_word  = r_data[{w_in_idx, w_in_off}];
    assign w_fill_addr = {w_req_idx, r_beat};
    // Byte-offset bits of the pc carry no information for word fetches
    assign w_unused    = ^{IF_pc[1:0], r_req_pc[1:0]};

    // Next-state and next-output decode; clr takes priority in every state
    always_comb begin
        w_state_nxt   = r_state;
        w_req_pc_nxt  = r_req_pc;
        w_beat_nxt    = r_beat;
        w_hold_nxt    = r_hold;
        w_ins_sgn_nxt = 1'b0;
        w_ins_nxt     = IF_ins;
        w_mc_req_nxt  = MC_req;
        w_mc_addr_nxt = MC_addr;
        w_data_we     = 1'b0;
        w_line_fill   = 1'b0;
        w_line_inval  = 1'b0;
        w_hit_inc     = 1'b0;
        w_miss_inc    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_mc_req_nxt = 1'b0;
                if (IF_pc_sgn && !clr) begin
                    if (w_hit) begin
                        w_ins_sgn_nxt = 1'b1;
                        w_ins_nxt     = w_hit_word;
                        w_hit_inc     = 1'b1;
                    end else begin
                        // Invalidate now so a half-filled line can never hit
                        w_state_nxt   = S_REFILL;
                        w_req_pc_nxt  = IF_pc;
                        w_beat_nxt    = '0;
                        w_mc_req_nxt  = 1'b1;
                        w_mc_addr_nxt = {IF_pc[31:2 + OFFSET_BITS], OFFSET_BITS'(0), 2'b00};
                        w_line_inval  = 1'b1;
                        w_miss_inc    = 1'b1;
                    end
                end
            end

            S_REFILL: begin
                if (clr) begin
                    if (MC_done) begin
                        w_state_nxt  = S_IDLE;
                        w_mc_req_nxt = 1'b0;
                    end else begin
                        // Beat still outstanding: wait it out before going idle
                        w_state_nxt  = S_DRAIN;
                        w_mc_req_nxt = 1'b1;
                    end
                end else if (MC_done) begin
                    w_data_we    = 1'b1;
                    w_mc_req_nxt = 1'b0;
                    if (r_beat == w_req_off) begin
                        w_hold_nxt = MC_data;
                    end
                    if (&r_beat) begin
                        w_line_fill   = 1'b1;
                        w_state_nxt   = S_RESP;
                        w_ins_sgn_nxt = 1'b1;
                        w_ins_nxt     = (r_beat == w_req_off) ? MC_data : r_hold;
                    end else begin
                        w_state_nxt   = S_GAP;
                        w_beat_nxt    = r_beat + OFFSET_BITS'(1);
                        w_mc_addr_nxt = MC_addr + 32'd4;
                    end
                end
            end

            S_GAP: begin
                if (clr) begin
                    w_state_nxt  = S_IDLE;
                    w_mc_req_nxt = 1'b0;
                end else begin
                    w_state_nxt  = S_REFILL;
                    w_mc_req_nxt = 1'b1;
                end
            end

            S_RESP: begin
                w_state_nxt  = S_IDLE;
                w_mc_req_nxt = 1'b0;
            end

            S_DRAIN: begin
                if (MC_done) begin
                    w_state_nxt  = S_IDLE;
                    w_mc_req_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt  = S_IDLE;
                w_mc_req_nxt = 1'b0;
            end
        endcase
    end

    // State, control and output registers; frozen while rdy is low
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_req_pc   <= '0;
            r_beat     <= '0;
            r_hold     <= '0;
            IF_ins_sgn <= 1'b0;
            IF_ins     <= '0;
            MC_req     <= 1'b0;
            MC_addr    <= '0;
        end else if (rdy) begin
            r_state    <= w_state_nxt;
            r_req_pc   <= w_req_pc_nxt;
            r_beat     <= w_beat_nxt;
            r_hold     <= w_hold_nxt;
            IF_ins_sgn <= w_ins_sgn_nxt;
            IF_ins     <= w_ins_nxt;
            MC_req     <= w_mc_req_nxt;
            MC_addr    <= w_mc_addr_nxt;
        end
    end

    // Line valid bits: cleared at refill start, set once the last beat lands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (rdy) begin
            if (w_line_inval) begin
                r_valid[w_in_idx] <= 1'b0;
            end
            if (w_line_fill) begin
                r_valid[w_req_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays, written only by refill beats
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (w_data_we) begin
                r_data[w_fill_addr] <= MC_data;
            end
            if (w_line_fill) begin
                r_tag[w_req_idx] <= w_req_tag;
            end
        end
    end

`ifdef ICACHE_PERF_EN
    // Accepted hit and miss counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rdy) begin
            if (w_hit_inc) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (w_miss_inc) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Directed self-checking bench for icache_responder: refill sequencing,
// hits, eviction, flush cases, rdy stall and mid-operation reset.
module tb_icache_responder;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic        IF_pc_sgn;
    logic [31:0] IF_pc;
    logic        IF_ins_sgn;
    logic [31:0] IF_ins;
    logic        MC_req;
    logic [31:0] MC_addr;
    logic        MC_done;
    logic [31:0] MC_data;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    icache_responder dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .clr        (clr),
        .IF_pc_sgn  (IF_pc_sgn),
        .IF_pc      (IF_pc),
        .IF_ins_sgn (IF_ins_sgn),
        .IF_ins     (IF_ins),
        .MC_req     (MC_req),
        .MC_addr    (MC_addr),
        .MC_done    (MC_done),
        .MC_data    (MC_data)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then stable for sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] pc);
        IF_pc_sgn = 1'b1;
        IF_pc     = pc;
        tick();
        IF_pc_sgn = 1'b0;
    endtask

    // Memory controller answering each beat one cycle after MC_req rises
    task automatic refill_line(input logic [31:0] base, input logic [31:0] d0, input int first);
        for (int b = first; b < 4; b++) begin
            chk("mc_req_up", 32'(MC_req), 32'd1);
            chk("mc_addr", MC_addr, base + 32'(4 * b));
            tick();
            chk("mc_req_held", 32'(MC_req), 32'd1);
            MC_done = 1'b1;
            MC_data = d0 + 32'(b);
            tick();
            MC_done = 1'b0;
            chk("mc_req_gap", 32'(MC_req), 32'd0);
            if (b < 3) begin
                tick();
            end
        end
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] word);
        chk({tag, "_sgn"}, 32'(IF_ins_sgn), 32'd1);
        chk({tag, "_ins"}, IF_ins, word);
        tick();
        chk({tag, "_single"}, 32'(IF_ins_sgn), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        rdy       = 1'b1;
        clr       = 1'b0;
        IF_pc_sgn = 1'b0;
        IF_pc     = '0;
        MC_done   = 1'b0;
        MC_data   = '0;

        // Reset values
        tick();
        tick();
        chk("rst_sgn", 32'(IF_ins_sgn), 32'd0);
        chk("rst_ins", IF_ins, 32'd0);
        chk("rst_req", 32'(MC_req), 32'd0);
        chk("rst_addr", MC_addr, 32'd0);
        rst = 1'b0;
        tick();

        // Cold miss at 0x10
        request(32'h10);
        chk("cold_no_resp", 32'(IF_ins_sgn), 32'd0);
        refill_line(32'h10, 32'hA0, 0);
        expect_resp("cold", 32'hA0);

        // Back-to-back hits
        IF_pc_sgn = 1'b1;
        for (int i = 1; i < 4; i++) begin
            IF_pc = 32'h10 + 32'(4 * i);
            tick();
            chk("b2b_sgn", 32'(IF_ins_sgn), 32'd1);
            chk("b2b_ins", IF_ins, 32'hA0 + 32'(i));
            chk("b2b_no_mc", 32'(MC_req), 32'd0);
        end
        IF_pc_sgn = 1'b0;
        tick();
        chk("b2b_end", 32'(IF_ins_sgn), 32'd0);

        // Conflict eviction on index 1
        request(32'h410);
        refill_line(32'h410, 32'hB0, 0);
        expect_resp("evict", 32'hB0);
        request(32'h10);
        chk("evicted_miss", 32'(MC_req), 32'd1);
        refill_line(32'h10, 32'hA0, 0);
        expect_resp("refetch", 32'hA0);

        // Miss on the last word of a line
        request(32'h3C);
        refill_line(32'h30, 32'hD0, 0);
        expect_resp("last_word", 32'hD3);

        // Flush while beat 1 is outstanding
        request(32'h20);
        tick();
        MC_done = 1'b1;
        MC_data = 32'hC0;
        tick();
        MC_done = 1'b0;
        tick();
        chk("fl_beat1_req", 32'(MC_req), 32'd1);
        chk("fl_beat1_addr", MC_addr, 32'h24);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("fl_drain_req", 32'(MC_req), 32'd1);
        chk("fl_drain_sgn", 32'(IF_ins_sgn), 32'd0);
        tick();
        chk("fl_drain_hold", 32'(MC_req), 32'd1);
        MC_done = 1'b1;
        MC_data = 32'hC1;
        tick();
        MC_done = 1'b0;
        chk("fl_done_req", 32'(MC_req), 32'd0);
        chk("fl_done_sgn", 32'(IF_ins_sgn), 32'd0);
        tick();
        chk("fl_idle_req", 32'(MC_req), 32'd0);
        chk("fl_idle_sgn", 32'(IF_ins_sgn), 32'd0);
        request(32'h20);
        chk("fl_remiss", 32'(MC_req), 32'd1);
        refill_line(32'h20, 32'hC0, 0);
        expect_resp("fl_refill", 32'hC0);

        // Hit request dropped by a same-cycle clr
        IF_pc_sgn = 1'b1;
        IF_pc     = 32'h14;
        clr       = 1'b1;
        tick();
        IF_pc_sgn = 1'b0;
        clr       = 1'b0;
        chk("clr_hit_sgn", 32'(IF_ins_sgn), 32'd0);
        chk("clr_hit_req", 32'(MC_req), 32'd0);

        // clr during a hit response squashes the next one
        IF_pc_sgn = 1'b1;
        IF_pc     = 32'h14;
        tick();
        chk("pre_clr_sgn", 32'(IF_ins_sgn), 32'd1);
        chk("pre_clr_ins", IF_ins, 32'hA1);
        IF_pc = 32'h18;
        clr   = 1'b1;
        tick();
        IF_pc_sgn = 1'b0;
        clr       = 1'b0;
        chk("post_clr_sgn", 32'(IF_ins_sgn), 32'd0);

        // clr together with MC_done: straight to idle
        request(32'h50);
        tick();
        MC_done = 1'b1;
        MC_data = 32'hF0;
        clr     = 1'b1;
        tick();
        MC_done = 1'b0;
        clr     = 1'b0;
        chk("cd_req", 32'(MC_req), 32'd0);
        chk("cd_sgn", 32'(IF_ins_sgn), 32'd0);
        tick();
        chk("cd_stay_idle", 32'(MC_req), 32'd0);
        request(32'h50);
        chk("cd_remiss", 32'(MC_req), 32'd1);
        refill_line(32'h50, 32'hF0, 0);
        expect_resp("cd_refill", 32'hF0);

        // rdy low for three cycles during beat 1
        request(32'h68);
        chk("rdy_addr0", MC_addr, 32'h60);
        tick();
        MC_done = 1'b1;
        MC_data = 32'hE0;
        tick();
        MC_done = 1'b0;
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rdy_req", 32'(MC_req), 32'd1);
            chk("rdy_addr", MC_addr, 32'h64);
        end
        rdy = 1'b1;
        refill_line(32'h60, 32'hE0, 1);
        expect_resp("rdy_resp", 32'hE2);
        request(32'h60);
        expect_resp("rdy_beat0", 32'hE0);

        // Reset in the middle of a refill
        request(32'h70);
        chk("mr_req_pre", 32'(MC_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_req", 32'(MC_req), 32'd0);
        chk("mr_addr", MC_addr, 32'd0);
        chk("mr_sgn", 32'(IF_ins_sgn), 32'd0);
        request(32'h10);
        chk("mr_cold_miss", 32'(MC_req), 32'd1);
        refill_line(32'h10, 32'hA0, 0);
        expect_resp("mr_refill", 32'hA0);
        request(32'h14);
        expect_resp("mr_hit", 32'hA1);

`ifdef ICACHE_PERF_EN
        // One miss and one hit since the last reset
        chk("hit_cnt", hit_cnt, 32'd1);
        chk("miss_cnt", miss_cnt, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
